ft245_fifo_bridge: RTL
======================

# ft245_fifo_bridge

Buffered, parametrised FT245 asynchronous-FIFO bridge: it moves bytes between the FT245 USB chip pins and the on-chip simple (rdy/ack) byte interface. Depth-configurable RX and TX FIFOs decouple the host side from the pin timing, so several bytes can be bursted in either direction. A round-robin arbiter replaces fixed RX priority, and pin timing is derived from nanosecond parameters. The block sits between the FT245 pads and the command/stream logic.

## Interface
- CLOCK_PERIOD_NS, 10, system clock period in ns
- RX_DEPTH, 16, RX FIFO entries; power of 2, ≥2
- TX_DEPTH, 16, TX FIFO entries; power of 2, ≥2
- WAIT_TIME_RX_NS, 30, RD# low time before sampling data
- INACTIVE_TIME_RX_NS, 14, RD# high time after a read
- SETUP_TIME_TX_NS, 5, data valid before WR# falls
- ACTIVE_TIME_TX_NS, 30, WR# low time
- HOLD_TIME_TX_NS, 5, data held after WR# rises
- clk  in  1  system clock; one clock, all logic on posedge
- rst  in  1  reset, synchronous and active-high
- rx_data_245  in  8  FT245 data bus (read)
- rxf_245  in  1  FT245 RXF#, low = byte available
- rx_245  out  1  FT245 RD#, active low
- tx_data_245  out  8  FT245 data bus (write)
- txe_245  in  1  FT245 TXE#, low = space available
- wr_245  out  1  FT245 WR, active low
- tx_oe_245  out  1  pad output enable for tx_data_245
- rx_data_si  out  8  RX FIFO head byte
- rx_rdy_si  out  1  RX FIFO non-empty
- rx_ack_si  in  1  pop RX head, qualified by rx_rdy_si
- tx_data_si  in  8  byte to send
- tx_rdy_si  in  1  byte offered
- tx_ack_si  out  1  byte accepted this cycle
- rx_level  out  $clog2(RX_DEPTH)+1  RX FIFO occupancy
- tx_level  out  $clog2(TX_DEPTH)+1  TX FIFO occupancy

## Operation
- Cycle counts: CNT_x = max(1, ceil(x_NS / CLOCK_PERIOD_NS)). At 10 ns: WAIT_RX=3, INACTIVE_RX=2, SETUP_TX=1, ACTIVE_TX=3, HOLD_TX=1.
- Reset values: rx_245=1, wr_245=1, tx_oe_245=0, tx_data_245=0, rx_rdy_si=0, tx_ack_si=0, rx_data_si=0, both levels=0, state=IDLE, last_grant=TX. Reset empties both FIFOs.
- Reset mid-transfer: everything is restored to reset values on the next edge and the in-flight byte is dropped. The pins must not glitch to any non-reset value during the reset cycle.
- tx_ack_si = tx_rdy_si & ~tx_full. This is combinational and independent of FSM state. An ack pushes tx_data_si.
- rx_data_si shows the head of the RX FIFO (show-ahead). rx_rdy_si & rx_ack_si pops. rx_ack_si while empty is ignored.
- Eligibility is evaluated in IDLE only:
  - rx_req = ~rxf_245 & ~rx_full
  - tx_req = ~txe_245 & ~tx_empty
  - If both are set, grant the opposite of last_grant. Otherwise grant the one that is set. Update last_grant on every grant.
- FSM states:
  - IDLE: on an RX grant, rx_245←0 and go to RX_WAIT. On a TX grant, tx_data_245←TX head, pop TX, tx_oe_245←1, and go to TX_SETUP.
  - RX_WAIT: hold for CNT_WAIT_RX cycles. On the last cycle, push rx_data_245, set rx_245←1, and go to RX_INACTIVE.
  - RX_INACTIVE: hold for CNT_INACTIVE_RX cycles, then go to IDLE.
  - TX_SETUP: hold for CNT_SETUP_TX cycles, then wr_245←0 and go to TX_ACTIVE.
  - TX_ACTIVE: hold for CNT_ACTIVE_TX cycles, then wr_245←1 and go to TX_HOLD.
  - TX_HOLD: hold for CNT_HOLD_TX cycles with data and OE stable, then tx_oe_245←0 and go to IDLE.
- FIFO full/empty:
  - The FSM is the only RX pusher and checks ~rx_full before granting, so RX overflow is impossible.
  - The FSM is the only TX popper and checks ~tx_empty before granting, so TX underflow is impossible.
- Simultaneous push and pop on the same FIFO are both performed and the level is unchanged. Full and empty are registered, so a full TX FIFO does not ack even if it is popped that cycle.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. Level is one bit wider so that full is distinguishable from empty.

## Timing
- RD# low pulse is exactly CNT_WAIT_RX cycles. Data is sampled on the final low cycle. RD# high time is at least CNT_INACTIVE_RX cycles, plus one IDLE cycle.
- The pushed RX byte is visible on rx_data_si/rx_rdy_si one cycle after the push edge.
- For TX, tx_oe_245 rises CNT_SETUP_TX cycles before WR# falls. WR# low lasts CNT_ACTIVE_TX cycles. OE and data persist CNT_HOLD_TX cycles after WR# rises.
- Per-byte cost at 10 ns:
  - RX: 1+3+2 = 6 cycles.
  - TX: 1+1+3+1 = 6 cycles.
- rxf_245 and txe_245 are used only in IDLE. Changes during a transfer are ignored.

## Structure
- Shared package ft245_pkg holds:
  - the state encoding constants (IDLE, RX_WAIT, RX_INACTIVE, TX_SETUP, TX_ACTIVE, TX_HOLD);
  - the grant encoding (GRANT_RX, GRANT_TX);
  - the ns_to_cycles(ns, period) constant function.
- One sub-module, ft245_sync_fifo #(WIDTH, DEPTH), instantiated twice (RX, TX). It provides show-ahead read, a level output, and registered full/empty.

## Test plan
- Reset, then idle: all outputs equal their reset values.
- RX with rxf_245 low: bytes 0xA5, 0x3C arrive and the host leaves rx_ack_si low. Required: rx_level becomes 2, rx_data_si=0xA5, each RD# pulse is 3 cycles low.
- TX: host offers 0x11, 0x22, 0x33 with txe_245 low. Required: all are acked. Pins show each byte with OE 1 cycle before WR#, WR# low 3 cycles, hold 1 cycle, in order.
- Both directions requesting continuously: grants alternate RX, TX, RX, TX starting with RX.
- Fill: RX_DEPTH=4, host never acks. Required: after 4 bytes rx_245 stays high with rxf_245 low. After one ack, exactly one more read occurs.
- rst asserted during TX_ACTIVE: next edge gives wr_245=1, tx_oe_245=0, tx_level=0, state IDLE.

Source files
------------

// File: rtl/ft245_pkg.sv
// Shared FSM/grant encodings and ns-to-cycle helpers for the FT245 bridge.
package ft245_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    RX_WAIT     = 3'd1,
    RX_INACTIVE = 3'd2,
    TX_SETUP    = 3'd3,
    TX_ACTIVE   = 3'd4,
    TX_HOLD     = 3'd5
  } state_t;

  typedef enum logic {
    GRANT_RX = 1'b0,
    GRANT_TX = 1'b1
  } grant_t;

  // Round a nanosecond duration up to whole clocks, never below one.
  function automatic int ns_to_cycles(input int ns, input int period);
    int c;
    c = (ns + period - 1) / period;
    return (c < 1) ? 1 : c;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ft245_sync_fifo.sv
// Show-ahead synchronous FIFO with registered full/empty and occupancy level.
module ft245_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  assign do_push = push_i & ~full_q;
  assign do_pop  = pop_i & ~empty_q;

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= (level_d == (AW+1)'(DEPTH));
      empty_q  <= (level_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Empty head reads as zero so stale storage never leaks to the outputs.
  assign head_o  = empty_q ? '0 : mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign level_o = level_q;

endmodule

// File: rtl/ft245_fifo_bridge.sv
// FT245 pin sequencer between buffered RX/TX byte FIFOs and the rdy/ack host side.
module ft245_fifo_bridge
  import ft245_pkg::*;
#(
  parameter int CLOCK_PERIOD_NS     = 10,
  parameter int RX_DEPTH            = 16,
  parameter int TX_DEPTH            = 16,
  parameter int WAIT_TIME_RX_NS     = 30,
  parameter int INACTIVE_TIME_RX_NS = 14,
  parameter int SETUP_TIME_TX_NS    = 5,
  parameter int ACTIVE_TIME_TX_NS   = 30,
  parameter int HOLD_TIME_TX_NS     = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  rx_data_245,
  input  logic                        rxf_245,
  output logic                        rx_245,
  output logic [7:0]                  tx_data_245,
  input  logic                        txe_245,
  output logic                        wr_245,
  output logic                        tx_oe_245,
  output logic [7:0]                  rx_data_si,
  output logic                        rx_rdy_si,
  input  logic                        rx_ack_si,
  input  logic [7:0]                  tx_data_si,
  input  logic                        tx_rdy_si,
  output logic                        tx_ack_si,
  output logic [$clog2(RX_DEPTH):0]   rx_level,
  output logic [$clog2(TX_DEPTH):0]   tx_level
);

  localparam int CNT_WAIT_RX     = ns_to_cycles(WAIT_TIME_RX_NS, CLOCK_PERIOD_NS);
  localparam int CNT_INACTIVE_RX = ns_to_cycles(INACTIVE_TIME_RX_NS, CLOCK_PERIOD_NS);
  localparam int CNT_SETUP_TX    = ns_to_cycles(SETUP_TIME_TX_NS, CLOCK_PERIOD_NS);
  localparam int CNT_ACTIVE_TX   = ns_to_cycles(ACTIVE_TIME_TX_NS, CLOCK_PERIOD_NS);
  localparam int CNT_HOLD_TX     = ns_to_cycles(HOLD_TIME_TX_NS, CLOCK_PERIOD_NS);
  localparam int CNT_MAX = max_int(max_int(max_int(CNT_WAIT_RX, CNT_INACTIVE_RX),
                                           max_int(CNT_SETUP_TX, CNT_ACTIVE_TX)), CNT_HOLD_TX);
  localparam int CW = $clog2(CNT_MAX + 1);

  state_t         state_q, state_d;
  grant_t         last_grant_q, last_grant_d, grant;
  logic [CW-1:0]  cnt_q, cnt_d, cnt_len;
  logic           cnt_last;
  logic           rx_245_q, rx_245_d, wr_245_q, wr_245_d, tx_oe_q, tx_oe_d;
  logic [7:0]     tx_data_q, tx_data_d, tx_head;
  logic           rx_full, rx_empty, tx_full, tx_empty;
  logic           rx_push, tx_pop, rx_req, tx_req, grant_valid;

  assign tx_ack_si = tx_rdy_si & ~tx_full;
  assign rx_rdy_si = ~rx_empty;

  ft245_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push_i(rx_push), .push_data_i(rx_data_245),
    .pop_i(rx_ack_si), .head_o(rx_data_si), .full_o(rx_full), .empty_o(rx_empty),
    .level_o(rx_level)
  );

  ft245_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push_i(tx_ack_si), .push_data_i(tx_data_si),
    .pop_i(tx_pop), .head_o(tx_head), .full_o(tx_full), .empty_o(tx_empty),
    .level_o(tx_level)
  );

  // Round-robin between directions; pin strobes are only looked at in IDLE.
  assign rx_req      = ~rxf_245 & ~rx_full;
  assign tx_req      = ~txe_245 & ~tx_empty;
  assign grant_valid = rx_req | tx_req;
  assign grant       = (rx_req & tx_req) ? ((last_grant_q == GRANT_RX) ? GRANT_TX : GRANT_RX)
                                         : (rx_req ? GRANT_RX : GRANT_TX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_TX;
      cnt_q        <= '0;
      rx_245_q     <= 1'b1;
      wr_245_q     <= 1'b1;
      tx_oe_q      <= 1'b0;
      tx_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      rx_245_q     <= rx_245_d;
      wr_245_q     <= wr_245_d;
      tx_oe_q      <= tx_oe_d;
      tx_data_q    <= tx_data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q + CW'(1);
    cnt_len      = '0;
    unique case (state_q)
      RX_WAIT:     cnt_len = CW'(CNT_WAIT_RX - 1);
      RX_INACTIVE: cnt_len = CW'(CNT_INACTIVE_RX - 1);
      TX_SETUP:    cnt_len = CW'(CNT_SETUP_TX - 1);
      TX_ACTIVE:   cnt_len = CW'(CNT_ACTIVE_TX - 1);
      TX_HOLD:     cnt_len = CW'(CNT_HOLD_TX - 1);
      default:     cnt_len = '0;
    endcase
    cnt_last = (cnt_q == cnt_len);
    if (state_q == IDLE) begin
      cnt_d = '0;
      if (grant_valid) begin
        last_grant_d = grant;
        state_d      = (grant == GRANT_RX) ? RX_WAIT : TX_SETUP;
      end
    end else if (cnt_last) begin
      cnt_d = '0;
      unique case (state_q)
        RX_WAIT:     state_d = RX_INACTIVE;
        TX_SETUP:    state_d = TX_ACTIVE;
        TX_ACTIVE:   state_d = TX_HOLD;
        default:     state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    rx_245_d  = rx_245_q;
    wr_245_d  = wr_245_q;
    tx_oe_d   = tx_oe_q;
    tx_data_d = tx_data_q;
    rx_push   = 1'b0;
    tx_pop    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_valid && grant == GRANT_RX) begin
          rx_245_d = 1'b0;
        end else if (grant_valid) begin
          tx_data_d = tx_head;
          tx_pop    = 1'b1;
          tx_oe_d   = 1'b1;
        end
      end
      RX_WAIT: begin
        if (cnt_last) begin
          rx_push  = 1'b1;
          rx_245_d = 1'b1;
        end
      end
      TX_SETUP:  if (cnt_last) wr_245_d = 1'b0;
      TX_ACTIVE: if (cnt_last) wr_245_d = 1'b1;
      TX_HOLD:   if (cnt_last) tx_oe_d = 1'b0;
      default: ;
    endcase
  end

  assign rx_245      = rx_245_q;
  assign wr_245      = wr_245_q;
  assign tx_oe_245   = tx_oe_q;
  assign tx_data_245 = tx_data_q;

endmodule
